// File: rtl/ball_motion_if.sv
// Ball physics stage interface: frame/launch controls in, position history out.
interface ball_motion_if #(
  parameter int unsigned TRAIL = 10
);
  logic                  update;
  logic                  launch;
  logic [9:0]            Vel_x;
  logic [9:0]            Vel_y;
  logic [9:0]            ballX;
  logic [8:0]            ballY;
  logic [10*TRAIL-1:0]   trail_x;
  logic [9*TRAIL-1:0]    trail_y;
  logic                  busy;
  logic                  bounce;

  modport master (
    output update, launch, Vel_x, Vel_y,
    input  ballX, ballY, trail_x, trail_y, busy, bounce
  );

  modport slave (
    input  update, launch, Vel_x, Vel_y,
    output ballX, ballY, trail_x, trail_y, busy, bounce
  );
endinterface

// File: rtl/ball_motion.sv
// Ball physics: launch, per-frame gravity, wall/ceiling reflection, damped floor
// bounces, settle phase, and a TRAIL-deep position history for the renderer.
module ball_motion #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned BALL_SIZE = 10,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned VMAX      = 31,
  parameter int unsigned START_X   = 20,
  parameter int unsigned START_Y   = 470,
  parameter int unsigned TRAIL     = 10
) (
  input  logic          clk,
  input  logic          rst,
  ball_motion_if.slave  bus
);

  localparam int unsigned CNT_W = (TRAIL > 1) ? $clog2(TRAIL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIL - 1);

  localparam logic signed [11:0] XMAX_S  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] FLOOR_S = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] VMAX_S  = 12'(VMAX);
  localparam logic signed [11:0] GRAV_S  = 12'(GRAVITY);
  localparam logic signed [11:0] ONE_S   = 12'sd1;

  localparam logic [9:0] START_X_V = 10'(START_X);
  localparam logic [8:0] START_Y_V = 9'(START_Y);
  localparam logic [9:0] XMAX_V    = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [8:0] FLOOR_V   = 9'(SCREEN_H - BALL_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_SETTLE
  } state_e;

  state_e                  state_q, state_d;
  logic [TRAIL-1:0][9:0]   tx_q, tx_d;
  logic [TRAIL-1:0][8:0]   ty_q, ty_d;
  logic signed [9:0]       vx_q, vx_d;
  logic signed [9:0]       vy_q, vy_d;
  logic                    bounce_q, bounce_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Motion datapath (evaluated every cycle, committed only on a FLIGHT update)
  logic signed [11:0]      vx_e, vy_e, nx, ny, vy_g, vy_abs, vy_half;
  logic signed [9:0]       vx_n, vy_n, vy_bnc, vx_next, vy_next;
  logic [9:0]              x_new;
  logic [8:0]              y_new;
  logic                    floor_hit, settle;
  logic [TRAIL-1:0][9:0]   tx_sh;
  logic [TRAIL-1:0][8:0]   ty_sh;

  // Next position/velocity from the current head of the trail.
  // One guard bit beyond 11 keeps extreme velocities from wrapping before clamping.
  always_comb begin
    vx_e    = {{2{vx_q[9]}}, vx_q};
    vy_e    = {{2{vy_q[9]}}, vy_q};
    nx      = $signed({2'b00, tx_q[0]}) + vx_e;
    ny      = $signed({3'b000, ty_q[0]}) + vy_e;
    vx_n    = -vx_q;
    vy_n    = -vy_q;
    vy_abs  = vy_e[11] ? -vy_e : vy_e;
    vy_half = vy_abs >>> 1;
    vy_bnc  = 10'(-vy_half);
    vy_g    = vy_e + GRAV_S;
    if (vy_g > VMAX_S) vy_g = VMAX_S;

    x_new     = nx[9:0];
    vx_next   = vx_q;
    if (nx < 0) begin
      x_new   = '0;
      vx_next = vx_n;
    end else if (nx > XMAX_S) begin
      x_new   = XMAX_V;
      vx_next = vx_n;
    end

    y_new     = ny[8:0];
    vy_next   = 10'(vy_g);
    floor_hit = 1'b0;
    settle    = 1'b0;
    if (ny < 0) begin
      y_new   = '0;
      vy_next = vy_n;
    end else if (ny >= FLOOR_S) begin
      y_new     = FLOOR_V;
      vy_next   = vy_bnc;
      floor_hit = 1'b1;
      settle    = (vy_half <= ONE_S);
    end
  end

  // Trail shifted by one entry; entry 0 is filled in by the FSM
  always_comb begin
    tx_sh    = tx_q;
    ty_sh    = ty_q;
    for (int unsigned k = 1; k < TRAIL; k++) begin
      tx_sh[k] = tx_q[k-1];
      ty_sh[k] = ty_q[k-1];
    end
  end

  // Next-state and register updates for IDLE / FLIGHT / SETTLE
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    bounce_d = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.launch) begin
          vx_d    = $signed(bus.Vel_x);
          vy_d    = $signed(bus.Vel_y);
          cnt_d   = '0;
          state_d = S_FLIGHT;
          for (int unsigned k = 0; k < TRAIL; k++) begin
            tx_d[k] = START_X_V;
            ty_d[k] = START_Y_V;
          end
        end
      end
      S_FLIGHT: begin
        if (bus.update) begin
          tx_d     = tx_sh;
          ty_d     = ty_sh;
          tx_d[0]  = x_new;
          ty_d[0]  = y_new;
          vx_d     = vx_next;
          vy_d     = vy_next;
          bounce_d = floor_hit;
          if (settle) begin
            vx_d    = '0;
            vy_d    = '0;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (bus.update) begin
          tx_d    = tx_sh;
          ty_d    = ty_sh;
          tx_d[0] = tx_q[0];
          ty_d[0] = ty_q[0];
          if (cnt_q == CNT_LAST) state_d = S_IDLE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      vx_q     <= '0;
      vy_q     <= '0;
      bounce_q <= 1'b0;
      cnt_q    <= '0;
      for (int unsigned k = 0; k < TRAIL; k++) begin
        tx_q[k] <= START_X_V;
        ty_q[k] <= START_Y_V;
      end
    end else begin
      state_q  <= state_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      bounce_q <= bounce_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
    end
  end

  assign bus.ballX   = tx_q[0];
  assign bus.ballY   = ty_q[0];
  assign bus.trail_x = tx_q;
  assign bus.trail_y = ty_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.bounce  = bounce_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: reset, flight, walls/ceiling, floor/settle,
// launch priority and mid-flight reset.
module tb_ball_motion;

  localparam int unsigned TRAIL = 10;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  ball_motion_if #(.TRAIL(TRAIL)) bus ();

  ball_motion #(
    .SCREEN_W (640),
    .SCREEN_H (480),
    .BALL_SIZE(10),
    .GRAVITY  (1),
    .VMAX     (31),
    .START_X  (20),
    .START_Y  (470),
    .TRAIL    (TRAIL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_update();
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  task automatic n_updates(input int n);
    for (int i = 0; i < n; i++) pulse_update();
  endtask

  task automatic pulse_launch(input logic signed [9:0] vx, input logic signed [9:0] vy);
    bus.Vel_x  = vx;
    bus.Vel_y  = vy;
    bus.launch = 1'b1;
    @(negedge clk);
    bus.launch = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd20, 9'd470})
      $display("FAIL reset_pos got (%0d,%0d) want (20,470)", bus.ballX, bus.ballY);
    else pass_cnt++;
    total_cnt++;
    if ({bus.busy, bus.bounce} !== 2'b00)
      $display("FAIL reset_flags got busy=%0b bounce=%0b want 0 0", bus.busy, bus.bounce);
    else pass_cnt++;
    for (int k = 0; k < TRAIL; k++) begin
      total_cnt++;
      if ({bus.trail_x[10*k +: 10], bus.trail_y[9*k +: 9]} !== {10'd20, 9'd470})
        $display("FAIL reset_trail%0d got (%0d,%0d) want (20,470)", k,
                 bus.trail_x[10*k +: 10], bus.trail_y[9*k +: 9]);
      else pass_cnt++;
    end
  endtask

  task automatic test_flight();
    do_reset();
    pulse_launch(10'sd5, -10'sd10);
    total_cnt++;
    if ({bus.busy, bus.ballX, bus.ballY} !== {1'b1, 10'd20, 9'd470})
      $display("FAIL launch got busy=%0b (%0d,%0d) want 1 (20,470)", bus.busy, bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd25, 9'd460})
      $display("FAIL flight_u1 got (%0d,%0d) want (25,460)", bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd30, 9'd451})
      $display("FAIL flight_u2 got (%0d,%0d) want (30,451)", bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd35, 9'd443})
      $display("FAIL flight_u3 got (%0d,%0d) want (35,443)", bus.ballX, bus.ballY);
    else pass_cnt++;
    total_cnt++;
    if ({bus.trail_x[20 +: 10], bus.trail_y[18 +: 9]} !== {10'd25, 9'd460})
      $display("FAIL trail2 got (%0d,%0d) want (25,460)", bus.trail_x[20 +: 10], bus.trail_y[18 +: 9]);
    else pass_cnt++;
    total_cnt++;
    if ({bus.trail_x[30 +: 10], bus.trail_y[27 +: 9]} !== {10'd20, 9'd470})
      $display("FAIL trail3 got (%0d,%0d) want (20,470)", bus.trail_x[30 +: 10], bus.trail_y[27 +: 9]);
    else pass_cnt++;
  endtask

  task automatic test_walls();
    do_reset();
    pulse_launch(10'sd152, -10'sd30);
    n_updates(4);
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd628, 9'd356})
      $display("FAIL wall_pre got (%0d,%0d) want (628,356)", bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if (bus.ballX !== 10'd630)
      $display("FAIL wall_right got %0d want 630", bus.ballX);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if (bus.ballX !== 10'd478)
      $display("FAIL wall_reflect got %0d want 478", bus.ballX);
    else pass_cnt++;
    n_updates(4);
    total_cnt++;
    if (bus.ballX !== 10'd0)
      $display("FAIL wall_left got %0d want 0", bus.ballX);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd152, 9'd195})
      $display("FAIL wall_left_reflect got (%0d,%0d) want (152,195)", bus.ballX, bus.ballY);
    else pass_cnt++;

    // Corner hit followed by terminal-velocity clamping
    do_reset();
    pulse_launch(-10'sd10, -10'sd200);
    n_updates(3);
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd0, 9'd0})
      $display("FAIL corner got (%0d,%0d) want (0,0)", bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd10, 9'd198})
      $display("FAIL corner_reflect got (%0d,%0d) want (10,198)", bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd20, 9'd229})
      $display("FAIL vmax_u5 got (%0d,%0d) want (20,229)", bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd30, 9'd260})
      $display("FAIL vmax_u6 got (%0d,%0d) want (30,260)", bus.ballX, bus.ballY);
    else pass_cnt++;
  endtask

  task automatic test_floor_settle();
    do_reset();
    pulse_launch(10'sd1, -10'sd8);
    n_updates(16);
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.bounce} !== {10'd36, 9'd462, 1'b0})
      $display("FAIL floor_pre got (%0d,%0d) b=%0b want (36,462) b=0", bus.ballX, bus.ballY, bus.bounce);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.bounce} !== {10'd37, 9'd470, 1'b1})
      $display("FAIL floor_hit got (%0d,%0d) b=%0b want (37,470) b=1", bus.ballX, bus.ballY, bus.bounce);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.bounce !== 1'b0)
      $display("FAIL bounce_pulse got %0b want 0", bus.bounce);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd38, 9'd466})
      $display("FAIL floor_damp got (%0d,%0d) want (38,466)", bus.ballX, bus.ballY);
    else pass_cnt++;
    n_updates(12);
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy} !== {10'd50, 9'd468, 1'b1})
      $display("FAIL floor_second got (%0d,%0d) busy=%0b want (50,468) 1", bus.ballX, bus.ballY, bus.busy);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.bounce, bus.busy} !== {10'd51, 9'd470, 1'b1, 1'b1})
      $display("FAIL settle_hit got (%0d,%0d) b=%0b busy=%0b want (51,470) 1 1",
               bus.ballX, bus.ballY, bus.bounce, bus.busy);
    else pass_cnt++;
    pulse_launch(10'sd3, -10'sd50);
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy} !== {10'd51, 9'd470, 1'b1})
      $display("FAIL settle_launch got (%0d,%0d) busy=%0b want (51,470) 1", bus.ballX, bus.ballY, bus.busy);
    else pass_cnt++;
    n_updates(9);
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy} !== {10'd51, 9'd470, 1'b1})
      $display("FAIL settle_9 got (%0d,%0d) busy=%0b want (51,470) 1", bus.ballX, bus.ballY, bus.busy);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.busy, bus.trail_x[90 +: 10], bus.trail_y[81 +: 9]} !== {1'b0, 10'd51, 9'd470})
      $display("FAIL settle_done got busy=%0b e9=(%0d,%0d) want 0 (51,470)",
               bus.busy, bus.trail_x[90 +: 10], bus.trail_y[81 +: 9]);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy} !== {10'd51, 9'd470, 1'b0})
      $display("FAIL idle_update got (%0d,%0d) busy=%0b want (51,470) 0", bus.ballX, bus.ballY, bus.busy);
    else pass_cnt++;
    pulse_launch(10'sd5, -10'sd10);
    total_cnt++;
    if ({bus.ballX, bus.trail_x[90 +: 10], bus.trail_y[81 +: 9], bus.busy} !== {10'd20, 10'd20, 9'd470, 1'b1})
      $display("FAIL relaunch got x=%0d e9=(%0d,%0d) busy=%0b want 20 (20,470) 1",
               bus.ballX, bus.trail_x[90 +: 10], bus.trail_y[81 +: 9], bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_launch_priority();
    do_reset();
    bus.Vel_x  = 10'sd5;
    bus.Vel_y  = -10'sd10;
    bus.launch = 1'b1;
    bus.update = 1'b1;
    @(negedge clk);
    bus.launch = 1'b0;
    bus.update = 1'b0;
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy} !== {10'd20, 9'd470, 1'b1})
      $display("FAIL launch_and_update got (%0d,%0d) busy=%0b want (20,470) 1", bus.ballX, bus.ballY, bus.busy);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd25, 9'd460})
      $display("FAIL lp_u1 got (%0d,%0d) want (25,460)", bus.ballX, bus.ballY);
    else pass_cnt++;
    pulse_launch(-10'sd100, 10'sd0);
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy} !== {10'd25, 9'd460, 1'b1})
      $display("FAIL flight_launch got (%0d,%0d) busy=%0b want (25,460) 1", bus.ballX, bus.ballY, bus.busy);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY} !== {10'd30, 9'd451})
      $display("FAIL flight_launch_u2 got (%0d,%0d) want (30,451)", bus.ballX, bus.ballY);
    else pass_cnt++;
  endtask

  task automatic test_midflight_reset();
    do_reset();
    pulse_launch(10'sd5, -10'sd10);
    n_updates(2);
    rst        = 1'b0;
    bus.update = 1'b1;
    @(negedge clk);
    rst        = 1'b1;
    bus.update = 1'b0;
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy, bus.bounce} !== {10'd20, 9'd470, 1'b0, 1'b0})
      $display("FAIL midflight_reset got (%0d,%0d) busy=%0b b=%0b want (20,470) 0 0",
               bus.ballX, bus.ballY, bus.busy, bus.bounce);
    else pass_cnt++;
    total_cnt++;
    if ({bus.trail_x[10 +: 10], bus.trail_y[9 +: 9]} !== {10'd20, 9'd470})
      $display("FAIL midflight_trail1 got (%0d,%0d) want (20,470)", bus.trail_x[10 +: 10], bus.trail_y[9 +: 9]);
    else pass_cnt++;
    pulse_update();
    total_cnt++;
    if ({bus.ballX, bus.ballY, bus.busy} !== {10'd20, 9'd470, 1'b0})
      $display("FAIL post_reset_update got (%0d,%0d) busy=%0b want (20,470) 0", bus.ballX, bus.ballY, bus.busy);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b0;
    bus.update = 1'b0;
    bus.launch = 1'b0;
    bus.Vel_x  = '0;
    bus.Vel_y  = '0;
    @(negedge clk);
    test_reset();
    test_flight();
    test_walls();
    test_floor_settle();
    test_launch_priority();
    test_midflight_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
